// File: rtl/stall_mem_ctrl.sv
// Multi-cycle single-ported word memory with data/fetch arbitration and stall generation.
// Optional one-entry instruction line buffer enabled by STALL_MEM_IBUF_EN.
module stall_mem_ctrl #(
   parameter int LATENCY = 4,
   parameter int DEPTH   = 1024,
   parameter int AW      = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dEn,
   input  logic        dWr,
   input  logic [15:0] dAddr,
   input  logic [15:0] dWrData,
   output logic [15:0] dRdData,
   output logic        dDone,
   input  logic        iEn,
   input  logic [15:0] iAddr,
   output logic [15:0] iRdData,
   output logic        iDone,
   output logic        memStall,
   output logic        fetchStall,
   output logic        err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DBUSY,
      S_IBUSY,
      S_DONE
   } state_t;

   logic [15:0]   r_mem [DEPTH];
   state_t        r_state;
   logic [3:0]    r_cnt;
   logic          r_wr;
   logic [15:0]   r_addr;
   logic [15:0]   r_wdata;
   logic [15:0]   r_drd;
   logic [15:0]   r_ird;
   logic          r_ddone;
   logic          r_idone;
   logic          r_err;

   logic [AW-1:0] w_ridx;
   logic [AW-1:0] w_iidx;
   logic          w_last;
   logic          w_commit;
   logic          w_dchg;
   logic          w_ichg;
   logic          w_ihit;
   logic [15:0]   w_ibdata;

   assign w_ridx   = r_addr[AW:1];
   assign w_iidx   = iAddr[AW:1];
   assign w_last   = (r_cnt == 4'd0);
   assign w_commit = rst && (r_state == S_DBUSY) && w_last && r_wr;

   // Request inputs must stay frozen for the whole busy window.
   assign w_dchg = (r_state == S_DBUSY) &&
                   (!dEn || (dWr != r_wr) ||
                    (dAddr != r_addr) || (dWrData != r_wdata));
   assign w_ichg = (r_state == S_IBUSY) &&
                   (!iEn || (iAddr != r_addr));

`ifdef STALL_MEM_IBUF_EN
   logic          r_ib_vld;
   logic [AW-1:0] r_ib_tag;
   logic [15:0]   r_ib_data;

   assign w_ihit   = r_ib_vld && (r_ib_tag == w_iidx);
   assign w_ibdata = r_ib_data;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ib_vld <= 1'b0;
      end else if (r_state == S_DBUSY && w_last && r_wr) begin
         if (r_ib_tag == w_ridx)
            r_ib_vld <= 1'b0;
      end else if (r_state == S_IBUSY && w_last) begin
         r_ib_vld  <= 1'b1;
         r_ib_tag  <= w_ridx;
         r_ib_data <= r_mem[w_ridx];
      end
   end
`else
   assign w_ihit   = 1'b0;
   assign w_ibdata = 16'h0000;
`endif

   always_ff @(posedge clk) begin
      if (w_commit)
         r_mem[w_ridx] <= r_wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_wr    <= 1'b0;
         r_addr  <= 16'h0000;
         r_wdata <= 16'h0000;
         r_drd   <= 16'h0000;
         r_ird   <= 16'h0000;
         r_ddone <= 1'b0;
         r_idone <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_ddone <= 1'b0;
         r_idone <= 1'b0;
         if (w_dchg || w_ichg)
            r_err <= 1'b1;
         unique case (r_state)
            S_IDLE: begin
               if (dEn) begin
                  r_state <= S_DBUSY;
                  r_wr    <= dWr;
                  r_addr  <= dAddr;
                  r_wdata <= dWrData;
                  r_cnt   <= 4'(LATENCY - 2);
                  if (dAddr[0])
                     r_err <= 1'b1;
               end else if (iEn) begin
                  if (iAddr[0])
                     r_err <= 1'b1;
                  if (w_ihit) begin
                     r_state <= S_DONE;
                     r_idone <= 1'b1;
                     r_ird   <= w_ibdata;
                  end else begin
                     r_state <= S_IBUSY;
                     r_wr    <= 1'b0;
                     r_addr  <= iAddr;
                     r_cnt   <= 4'(LATENCY - 2);
                  end
               end
            end
            S_DBUSY: begin
               if (w_last) begin
                  r_state <= S_DONE;
                  r_ddone <= 1'b1;
                  if (!r_wr)
                     r_drd <= r_mem[w_ridx];
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_IBUSY: begin
               if (w_last) begin
                  r_state <= S_DONE;
                  r_idone <= 1'b1;
                  r_ird   <= r_mem[w_ridx];
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign dRdData    = r_drd;
   assign iRdData    = r_ird;
   assign dDone      = r_ddone;
   assign iDone      = r_idone;
   assign err        = r_err;
   assign memStall   = dEn & ~r_ddone;
   assign fetchStall = iEn & ~r_idone;

endmodule

// File: doc/stall_mem_ctrl.md
Name: stall_mem_ctrl

Overview:
- Multi-cycle, single-ported, word-organised memory with a built-in stall controller.
- Serves the fetch-stage instruction port and the memory-stage data port of the pipelined processor.
- Arbitrates between the two ports and runs one access at a time over a fixed LATENCY.
- Produces the memStall and fetch stall signals that freeze the pipeline while an access is outstanding.

Parameters:
- LATENCY, 4: cycles from first request cycle to done cycle. Legal range 2..15.
- DEPTH, 1024: number of 16-bit words in the internal array.
- AW, 10: word-index width; log2(DEPTH).

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- dEn  in  1  data access request (memory stage); held until dDone.
- dWr  in  1  1 = store, 0 = load; qualified by dEn.
- dAddr  in  16  data byte address; word-aligned.
- dWrData  in  16  store data.
- dRdData  out  16  load data; valid in dDone cycle, held until the next load completes.
- dDone  out  1  one-cycle completion pulse for the data port.
- iEn  in  1  instruction fetch request; held until iDone.
- iAddr  in  16  fetch byte address; word-aligned.
- iRdData  out  16  fetched instruction; valid in iDone cycle, then held.
- iDone  out  1  one-cycle completion pulse for the instruction port.
- memStall  out  1  dEn & ~dDone (combinational).
- fetchStall  out  1  iEn & ~iDone (combinational).
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset (rst=0 at an edge):
  - FSM returns to IDLE; counter cleared.
  - dDone, iDone, err, dRdData and iRdData are all 0.
  - An in-flight access is abandoned; a pending store is NOT committed.
  - Array contents are not cleared.
- FSM states:
  - IDLE: sample requests. dEn wins over iEn (data priority). A winner moves the FSM to DBUSY or IBUSY and latches op, address and write data; the counter loads LATENCY-2.
  - DBUSY / IBUSY: counter decrements each cycle. At counter == 0, the access is performed at the edge:
    - Store: writes array[addr[AW:1]].
    - Load: captures the word into dRdData or iRdData.
    - The matching done register is set and the FSM moves to DONE.
  - DONE: exactly one cycle, with dDone or iDone = 1. Returns to IDLE. No request is sampled in DONE.
- Timing with the request first high in cycle 0:
  - Done is high in cycle LATENCY-1+1 = LATENCY; stall is high in cycles 0..LATENCY-1.
  - A store is visible to a load that starts in cycle LATENCY+1 or later.
  - A request still high in the cycle after done is treated as a new access, starting in that cycle.
- Back-to-back accesses have a period of LATENCY+1 cycles.
- Losing port: it keeps stalling and is accepted in the first IDLE cycle in which no data request is present.
- Address mapping: word index = addr[AW:1]. Upper bits above AW are ignored (aliasing).
- err is set (sticky until reset) on any of:
  - addr[0] = 1 on an accepted request; the access still proceeds with the bit ignored.
  - dEn, dWr, dAddr or dWrData changing while DBUSY.
  - iEn or iAddr changing while IBUSY.
- Read data is registered, never combinational from the array.

Optional Feature:
- Macro: STALL_MEM_IBUF_EN.
- Defined: one-entry instruction line buffer holding tag = word index, data and valid.
  - Any completed fetch fills the buffer.
  - In IDLE, if iEn is high, dEn is low, and iAddr hits a valid entry, the FSM goes straight to DONE with iRdData = buffered word. iDone is then high one cycle after request, in cycle 1.
  - A committed store to the buffered word index clears valid.
  - Reset clears valid.
- Undefined: no buffer; every fetch takes LATENCY cycles.

Test Plan:
- Reset with dEn=1, dWr=1 held mid-DBUSY (cycle 2) -> after reset, a load of the same address returns the old contents. dDone never pulses. err=0.
- Store 0xBEEF to 0x0010 at cycle 0 (LATENCY=4) -> memStall=1 in cycles 0-3, dDone=1 in cycle 4 only. Load of 0x0010 starting cycle 5 gives dDone in cycle 9 with dRdData=0xBEEF.
- dEn and iEn both raised in cycle 0 -> data done in cycle 4, fetchStall=1 through cycle 8, iDone in cycle 9.
- Load from 0x0003 -> err=1 and stays 1. The data returned is the word at index 1.
- dAddr changed from 0x0020 to 0x0022 in cycle 2 of a load -> err=1.
- With STALL_MEM_IBUF_EN: fetch 0x0040 (iDone cycle 4), re-fetch starting cycle 5 -> iDone in cycle 6. A store to 0x0040, then a fetch -> full LATENCY path and the new data. Without the macro: the re-fetch gives iDone in cycle 9.
